// File: rtl/i2c_segment_master_tx.sv
// Write-only I2C initiator: START, address+W, ACK, one data byte, ACK, STOP.
// Lines are open-drain: the block only asserts output enables that pull low.
// Each bit cell is four quarters of CLK_DIV clocks; responder stretching is
// honoured in the SCL-high quarter (Q1).
module i2c_segment_master_tx #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       nack
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StAddr,
        StAddrAck,
        StData,
        StDataAck,
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [1:0]      qtr_q, qtr_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            nack_q, nack_d;
    logic            done_q, done_d;
    logic            init_q;

    logic accept;
    logic in_q1;
    logic stretch;
    logic tick;

    assign accept    = req_valid && req_ready;
    assign req_ready = init_q && (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    // nack is only meaningful alongside done; keep it quiet otherwise
    assign nack      = done_q & nack_q;

    // Quarter divider with clock-stretch hold at the start of the SCL-high quarter
    always_comb begin
        in_q1   = 1'b0;
        stretch = 1'b0;
        tick    = 1'b0;
        div_d   = div_q;
        if (qtr_q == 2'd1) begin
            in_q1 = (state_q == StAddr) || (state_q == StAddrAck) ||
                    (state_q == StData) || (state_q == StDataAck) ||
                    (state_q == StStop);
        end
        stretch = in_q1 && (div_q == '0) && !scl_in;
        if (state_q == StIdle) begin
            div_d = '0;
        end else if (stretch) begin
            div_d = div_q;
        end else if (div_q == DivMax) begin
            div_d = '0;
            tick  = 1'b1;
        end else begin
            div_d = div_q + DivW'(1);
        end
    end

    // Sequencer: next state, quarter/bit counters, shift register, ACK result
    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        nack_d  = nack_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StStart;
                    qtr_d   = 2'd0;
                    bit_d   = 3'd0;
                    shift_d = {req_addr, 1'b0};
                    data_d  = req_data;
                    nack_d  = 1'b0;
                end
            end
            StStart: begin
                if (tick) begin
                    if (qtr_q == 2'd1) begin
                        state_d = StAddr;
                        qtr_d   = 2'd0;
                        bit_d   = 3'd0;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            StAddr, StData: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        if (bit_q == 3'd7) begin
                            bit_d   = 3'd0;
                            state_d = (state_q == StAddr) ? StAddrAck : StDataAck;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
            end
            StAddrAck: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    // Last cycle of Q2 is the ACK sample point
                    if (qtr_q == 2'd2) begin
                        nack_d = sda_in;
                    end
                    if (qtr_q == 2'd3) begin
                        if (nack_q) begin
                            state_d = StStop;
                        end else begin
                            state_d = StData;
                            shift_d = data_q;
                        end
                    end
                end
            end
            StDataAck: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd2) begin
                        nack_d = nack_q | sda_in;
                    end
                    if (qtr_q == 2'd3) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Line drivers decoded from state and quarter
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        unique case (state_q)
            StIdle: begin
                scl_oe = 1'b0;
                sda_oe = 1'b0;
            end
            StStart: begin
                sda_oe = 1'b1;
                scl_oe = (qtr_q == 2'd1);
            end
            StAddr, StData: begin
                scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
                sda_oe = ~shift_q[7];
            end
            StAddrAck, StDataAck: begin
                scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
                sda_oe = 1'b0;
            end
            StStop: begin
                scl_oe = (qtr_q == 2'd0);
                sda_oe = (qtr_q == 2'd0) || (qtr_q == 2'd1);
            end
            default: begin
                scl_oe = 1'b0;
                sda_oe = 1'b0;
            end
        endcase
    end

    // State registers; reset releases both lines at once (no STOP)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            div_q   <= '0;
            qtr_q   <= 2'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            data_q  <= 8'd0;
            nack_q  <= 1'b0;
            done_q  <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            nack_q  <= nack_d;
            done_q  <= done_d;
            init_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_i2c_segment_master_tx.sv
// Bench for i2c_segment_master_tx: open-drain bus with a responder model
// (ACK/NACK, clock stretching), vector table plus scoreboard queue.
module tb_i2c_segment_master_tx;

    localparam int unsigned CLK_DIV = 4;
    localparam int Bound = 1000;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       scl_in;
    logic       sda_in;
    logic       scl_oe;
    logic       sda_oe;
    logic       busy;
    logic       done;
    logic       nack;

    i2c_segment_master_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .busy      (busy),
        .done      (done),
        .nack      (nack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Responder model state (driver writes config, monitor writes the rest)
    bit   ack_addr = 1'b1;
    bit   ack_data = 1'b1;
    int   stretch_cell = -1;
    logic slave_sda_low = 1'b0;
    int   hold_left = 0;
    int   rise_cnt = 0;
    int   oe_falls = 0;
    int   starts = 0;
    int   stops = 0;
    logic samp [0:31];
    logic prev_scl = 1'b1;
    logic prev_sda = 1'b1;
    logic prev_scl_oe = 1'b0;

    assign scl_in = ~scl_oe & ~(hold_left > 0);
    assign sda_in = ~sda_oe & ~slave_sda_low;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
        bit         aa;
        bit         ad;
        int         stretch;
        int         pulse_at;
    } vec_t;

    typedef struct {
        int         cycles;
        bit         nack;
        int         rises;
        logic [7:0] abyte;
        logic [7:0] dbyte;
        bit         aa;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs [0:6];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Bus monitor and responder, evaluated mid-cycle
    initial begin
        logic scl_b, sda_b;
        for (int i = 0; i < 32; i++) samp[i] = 1'b1;
        forever begin
            @(negedge clk);
            if (req_valid && req_ready) begin
                rise_cnt = 0;
                oe_falls = 0;
                starts = 0;
                stops = 0;
                hold_left = 0;
                slave_sda_low = 1'b0;
                for (int i = 0; i < 32; i++) samp[i] = 1'b1;
            end
            if (hold_left > 0) begin
                hold_left--;
            end else if (prev_scl_oe && !scl_oe && busy) begin
                if (oe_falls == stretch_cell) hold_left = 20;
                oe_falls++;
            end
            scl_b = ~scl_oe & ~(hold_left > 0);
            sda_b = ~sda_oe & ~slave_sda_low;
            if (!prev_scl && scl_b) begin
                if (rise_cnt < 32) samp[rise_cnt] = sda_b;
                rise_cnt++;
            end
            if (prev_scl && scl_b && prev_sda && !sda_b) starts++;
            if (prev_scl && scl_b && !prev_sda && sda_b) stops++;
            if (prev_scl && !scl_b) begin
                if (rise_cnt == 8 && ack_addr) slave_sda_low = 1'b1;
                if (rise_cnt == 9) slave_sda_low = 1'b0;
                if (rise_cnt == 17 && ack_data) slave_sda_low = 1'b1;
                if (rise_cnt == 18) slave_sda_low = 1'b0;
            end
            prev_scl = scl_b;
            prev_sda = ~sda_oe & ~slave_sda_low;
            prev_scl_oe = scl_oe;
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        exp_t got_e;
        int cyc;
        bit got;
        bit ready_hi;
        bit rdy_at_done;
        bit nack_at_done;
        int extra_done;
        int extra_busy;
        logic [7:0] ab;
        logic [7:0] db;

        ack_addr = v.aa;
        ack_data = v.ad;
        stretch_cell = v.stretch;

        @(posedge clk);
        #1;
        req_addr = v.addr;
        req_data = v.data;
        req_valid = 1'b1;
        e.cycles = (v.aa ? 78 : 42) * CLK_DIV + ((v.stretch >= 0) ? 20 : 0);
        e.nack = !v.aa || !v.ad;
        e.rises = v.aa ? 19 : 10;
        e.abyte = {v.addr, 1'b0};
        e.dbyte = v.data;
        e.aa = v.aa;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk({tag, " busy_after_accept"}, int'(busy), 1);

        cyc = 0;
        got = 1'b0;
        ready_hi = 1'b0;
        rdy_at_done = 1'b0;
        nack_at_done = 1'b0;
        while (cyc < Bound && !got) begin
            @(posedge clk);
            #1;
            cyc++;
            if (v.pulse_at >= 0 && cyc == v.pulse_at) begin
                req_valid = 1'b1;
                req_addr = 7'h11;
            end else begin
                req_valid = 1'b0;
            end
            if (done) begin
                got = 1'b1;
                rdy_at_done = req_ready;
                nack_at_done = nack;
            end else if (req_ready) begin
                ready_hi = 1'b1;
            end
        end
        if (!got) begin
            chk({tag, " done_timeout"}, 0, 1);
            return;
        end

        got_e = exp_q.pop_front();
        for (int i = 0; i < 8; i++) begin
            ab[7-i] = samp[i];
            db[7-i] = samp[9+i];
        end
        chk({tag, " done_cycle"}, cyc, got_e.cycles);
        chk({tag, " nack"}, int'(nack_at_done), int'(got_e.nack));
        chk({tag, " ready_at_done"}, int'(rdy_at_done), 1);
        chk({tag, " ready_low_while_busy"}, int'(ready_hi), 0);
        chk({tag, " scl_rises"}, rise_cnt, got_e.rises);
        chk({tag, " addr_bits"}, int'(ab), int'(got_e.abyte));
        chk({tag, " addr_ack_sample"}, int'(samp[8]), int'(!got_e.aa));
        if (got_e.aa) begin
            chk({tag, " data_bits"}, int'(db), int'(got_e.dbyte));
        end
        chk({tag, " start_cond"}, starts, 1);
        chk({tag, " stop_cond"}, stops, 1);

        @(posedge clk);
        #1;
        chk({tag, " done_width"}, int'(done), 0);
        extra_done = 0;
        extra_busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        chk({tag, " no_extra_done"}, extra_done, 0);
        chk({tag, " stays_idle"}, extra_busy, 0);
    endtask

    initial begin
        int cyc;

        vecs[0] = '{addr: 7'h3C, data: 8'hA5, aa: 1'b1, ad: 1'b1, stretch: -1, pulse_at: -1};
        vecs[1] = '{addr: 7'h3C, data: 8'hA5, aa: 1'b0, ad: 1'b1, stretch: -1, pulse_at: -1};
        vecs[2] = '{addr: 7'h3C, data: 8'hA5, aa: 1'b1, ad: 1'b0, stretch: -1, pulse_at: -1};
        vecs[3] = '{addr: 7'h3C, data: 8'hA5, aa: 1'b1, ad: 1'b1, stretch: -1, pulse_at: -1};
        vecs[4] = '{addr: 7'h3C, data: 8'hA5, aa: 1'b1, ad: 1'b1, stretch: 3, pulse_at: -1};
        vecs[5] = '{addr: 7'h3C, data: 8'hA5, aa: 1'b1, ad: 1'b1, stretch: -1, pulse_at: 50};
        vecs[6] = '{addr: 7'h55, data: 8'h0F, aa: 1'b1, ad: 1'b1, stretch: -1, pulse_at: -1};

        rst_n = 1'b0;
        req_valid = 1'b0;
        req_addr = 7'h0;
        req_data = 8'h0;

        #3;
        chk("rst req_ready", int'(req_ready), 0);
        chk("rst scl_oe", int'(scl_oe), 0);
        chk("rst sda_oe", int'(sda_oe), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst nack", int'(nack), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", int'(req_ready), 0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", int'(req_ready), 1);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Reset in the middle of the address byte
        ack_addr = 1'b1;
        ack_data = 1'b1;
        stretch_cell = -1;
        @(posedge clk);
        #1;
        req_addr = 7'h3C;
        req_data = 8'hA5;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        #2;
        chk("mid scl_oe_before_reset", int'(scl_oe), 1);
        rst_n = 1'b0;
        #1;
        chk("mid scl_oe", int'(scl_oe), 0);
        chk("mid sda_oe", int'(sda_oe), 0);
        chk("mid done", int'(done), 0);
        chk("mid nack", int'(nack), 0);
        chk("mid busy", int'(busy), 0);
        chk("mid req_ready", int'(req_ready), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid ready_after_release", int'(req_ready), 1);

        run_vec(vecs[6], "v6");

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
